// File: rtl/quant_module.sv
// Wishbone classic slave: quantizes an 8x8 DCT block (rounded divide by Q) and stores it zig-zag ordered.
// One restoring divider, 18 cycles per coefficient; bus accesses are acked one cycle after strobe and never stall the datapath.
module quant_module (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic [31:0] ADR_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  input  logic [3:0]  SEL_I,
  output logic        ACK_O,
  output logic        INT_O
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  logic [31:0] c_mem [64];
  logic [7:0]  q_mem [64];
  logic [15:0] o_mem [64];

  logic [2:0]  state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        sign_q, sign_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;
  logic        ack_q;
  logic [31:0] dat_q;

  logic [7:0]  adr;
  logic        bus_req, bus_wr, busy, start;
  logic [31:0] rd_data;
  logic [5:0]  n_idx;
  logic [31:0] c_raw;
  logic [7:0]  q_raw, qe;
  logic [14:0] mag;
  logic [8:0]  rem_sh;
  logic [15:0] o_val;
  logic        unused_bits;

  assign adr         = ADR_I[7:0];
  assign bus_req     = STB_I & CYC_I & ~ack_q;
  assign bus_wr      = bus_req & WE_I;
  assign busy        = (state_q != S_IDLE);
  assign start       = bus_wr & (adr == 8'd128) & DAT_I[0] & ~busy;
  assign unused_bits = ^{SEL_I, ADR_I[31:8]};

  // Datapath front end: saturate to +/-32767, split sign/magnitude, add half-divisor for rounding.
  assign n_idx = ZZ[k_q];
  assign c_raw = c_mem[n_idx];
  assign q_raw = q_mem[n_idx];
  assign qe    = (q_raw == 8'd0) ? 8'd1 : q_raw;

  always_comb begin
    mag = c_raw[14:0];
    if ($signed(c_raw) > 32'sd32767 || $signed(c_raw) < -32'sd32767)
      mag = 15'h7FFF;
    else if (c_raw[31])
      mag = 15'(-c_raw);
  end

  assign rem_sh = {rem_q, quo_q[15]};
  assign o_val  = sign_q ? 16'(-quo_q) : quo_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    sign_d  = sign_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        done_d  = 1'b0;
        k_d     = 6'd0;
      end
      S_LOAD: begin
        sign_d  = c_raw[31];
        div_d   = qe;
        quo_d   = {1'b0, mag} + {9'd0, qe[7:1]};
        rem_d   = 8'd0;
        cnt_d   = 4'd0;
        state_d = S_DIV;
      end
      S_DIV: begin
        // Restoring step: remainder stays below the divisor, so 8 bits hold it.
        if (rem_sh >= {1'b0, div_q}) begin
          rem_d = 8'(rem_sh - {1'b0, div_q});
          quo_d = {quo_q[14:0], 1'b1};
        end else begin
          rem_d = rem_sh[7:0];
          quo_d = {quo_q[14:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_STORE;
      end
      S_STORE: begin
        if (k_q == 6'd63) state_d = S_FIN;
        else begin
          k_d     = k_q + 6'd1;
          state_d = S_LOAD;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        k_d     = 6'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = 32'd0;
    if (adr < 8'd64)         rd_data = c_mem[adr[5:0]];
    else if (adr < 8'd128)   rd_data = {24'd0, q_mem[adr[5:0]]};
    else if (adr == 8'd129)  rd_data = {30'd0, done_q, busy};
    else if (adr >= 8'd192)  rd_data = {{16{o_mem[adr[5:0]][15]}}, o_mem[adr[5:0]]};
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_IDLE;
      k_q     <= 6'd0;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      div_q   <= 8'd1;
      quo_q   <= 16'd0;
      rem_q   <= 8'd0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ack_q   <= bus_req;
      if (bus_req) dat_q <= rd_data;
    end
  end

  // Buffers carry no reset; host writes are dropped while a run is in progress.
  always_ff @(posedge CLK_I) begin
    if (bus_wr && !busy && adr < 8'd64)                  c_mem[adr[5:0]] <= DAT_I;
    if (bus_wr && !busy && adr >= 8'd64 && adr < 8'd128) q_mem[adr[5:0]] <= DAT_I[7:0];
    if (state_q == S_STORE)                              o_mem[k_q] <= o_val;
  end

  assign ACK_O = ack_q;
  assign DAT_O = dat_q;
  assign INT_O = done_q;

endmodule

// File: tb/tb_quant_module.sv
// Self-checking bench for quant_module: random blocks compared against an arithmetic reference model.
module tb_quant_module;
  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] DAT_I = '0;
  logic [31:0] ADR_I = '0;
  logic        WE_I  = 1'b0;
  logic        STB_I = 1'b0;
  logic        CYC_I = 1'b0;
  logic [3:0]  SEL_I = 4'hF;
  wire  [31:0] DAT_O;
  wire         ACK_O;
  wire         INT_O;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;

  logic signed [31:0] c_m [64];
  logic [7:0]         q_m [64];
  int                 zz  [64];
  logic [31:0]        got [64];

  quant_module dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ADR_I(ADR_I),
    .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I), .SEL_I(SEL_I), .ACK_O(ACK_O), .INT_O(INT_O));

  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Zig-zag order by walking anti-diagonals, alternating direction.
  function automatic void build_zz();
    int idx = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz[idx] = r * 8 + (s - r); idx++; end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin zz[idx] = r * 8 + (s - r); idx++; end
      end
    end
  endfunction

  function automatic logic [31:0] model_out(int k);
    longint c = c_m[zz[k]];
    longint m;
    int     qe, qv;
    if (c > 32767) c = 32767;
    else if (c < -32767) c = -32767;
    m  = (c < 0) ? -c : c;
    qe = (q_m[zz[k]] == 0) ? 1 : int'(q_m[zz[k]]);
    qv = int'((m + qe / 2) / qe);
    return (c < 0) ? -qv : qv;
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat, output logic [31:0] rdat);
    int t = 0;
    @(posedge CLK_I); #1;
    ADR_I = adr; DAT_I = wdat; WE_I = we; STB_I = 1'b1; CYC_I = 1'b1;
    do begin @(posedge CLK_I); #1; t++; end while (!ACK_O && t < 8);
    rdat = DAT_O;
    if (!ACK_O) begin errors++; $display("FAIL ack_timeout adr=%0d got_ack=0 required_ack=1", adr); end
    STB_I = 1'b0; CYC_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic load_block();
    logic [31:0] d;
    for (int n = 0; n < 64; n++) wb_xfer(1'b1, n, c_m[n], d);
    for (int n = 0; n < 64; n++) wb_xfer(1'b1, 64 + n, {24'hABCDEF, q_m[n]}, d);
  endtask

  task automatic start_run();
    logic [31:0] d;
    wb_xfer(1'b1, 128, 32'd1, d);
    start_cyc = cyc;
  endtask

  task automatic wait_done(output int unsigned lat);
    while (!INT_O && (cyc - start_cyc) < 3000) begin @(posedge CLK_I); #1; end
    lat = cyc - start_cyc;
  endtask

  task automatic read_outputs();
    for (int k = 0; k < 64; k++) wb_xfer(1'b0, 192 + k, 32'd0, got[k]);
  endtask

  function automatic logic signed [31:0] rand_coef();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $signed($urandom_range(0, 4000)) - 2000;
      2: return $signed($urandom_range(0, 80000)) - 40000;
      default: return $signed($urandom_range(0, 64)) - 32;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(posedge CLK_I);
    #2;
    checks++;
    if (ACK_O !== 1'b0 || DAT_O !== 32'd0 || INT_O !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got ack=%b dat=%h int=%b required 0/0/0", ACK_O, DAT_O, INT_O);
    end
    @(posedge CLK_I); #1 RST_I = 1'b1;
    wb_xfer(1'b0, 129, 32'd0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_status got %h required 0", d); end
    wb_xfer(1'b0, 150, 32'd0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h required 0", d); end
  endtask

  task automatic test_unity();
    int unsigned lat;
    logic [31:0] d;
    for (int n = 0; n < 64; n++) begin c_m[n] = n; q_m[n] = 8'd1; end
    load_block();
    start_run();
    wait_done(lat);
    checks++;
    if (lat !== 1153) begin errors++; $display("FAIL unity_latency got %0d required 1153", lat); end
    wb_xfer(1'b0, 129, 32'd0, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL unity_status got %h required 2", d); end
    read_outputs();
    checks++;
    if (got[2] !== 32'd8 || got[63] !== 32'd63) begin
      errors++; $display("FAIL unity_O2_O63 got %0d/%0d required 8/63", got[2], got[63]);
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (got[k] !== zz[k]) begin errors++; $display("FAIL unity_O[%0d] got %0d required %0d", k, got[k], zz[k]); end
    end
  endtask

  task automatic test_rounding();
    int unsigned lat;
    for (int n = 0; n < 64; n++) begin c_m[n] = rand_coef(); q_m[n] = 8'd10; end
    c_m[0] = 25; c_m[1] = -25; c_m[8] = 24; c_m[16] = -4;
    load_block();
    start_run();
    wait_done(lat);
    read_outputs();
    checks++;
    if (got[0] !== 32'd3 || got[1] !== 32'hFFFF_FFFD || got[2] !== 32'd2 || got[3] !== 32'd0) begin
      errors++; $display("FAIL rounding got %h %h %h %h required 3 fffffffd 2 0", got[0], got[1], got[2], got[3]);
    end
    for (int k = 4; k < 64; k++) begin
      checks++;
      if (got[k] !== model_out(k)) begin errors++; $display("FAIL rounding_O[%0d] got %h required %h", k, got[k], model_out(k)); end
    end
  endtask

  task automatic test_saturation();
    int unsigned lat;
    for (int n = 0; n < 64; n++) begin c_m[n] = $urandom; q_m[n] = 8'd0; end
    c_m[0] = 100000; c_m[1] = -100000;
    load_block();
    start_run();
    wait_done(lat);
    read_outputs();
    checks++;
    if (got[0] !== 32'd32767 || got[1] !== -32'sd32767) begin
      errors++; $display("FAIL saturation got %h %h required 00007fff ffff8001", got[0], got[1]);
    end
    for (int k = 2; k < 64; k++) begin
      checks++;
      if (got[k] !== model_out(k)) begin errors++; $display("FAIL sat_O[%0d] got %h required %h", k, got[k], model_out(k)); end
    end
  endtask

  task automatic test_random();
    int unsigned lat;
    logic [31:0] d;
    for (int it = 0; it < 2; it++) begin
      for (int n = 0; n < 64; n++) begin c_m[n] = rand_coef(); q_m[n] = 8'($urandom_range(0, 255)); end
      load_block();
      for (int j = 0; j < 4; j++) begin
        int n = $urandom_range(0, 63);
        wb_xfer(1'b0, n, 32'd0, d);
        checks++;
        if (d !== c_m[n]) begin errors++; $display("FAIL readback_C[%0d] got %h required %h", n, d, c_m[n]); end
        wb_xfer(1'b0, 64 + n, 32'd0, d);
        checks++;
        if (d !== {24'd0, q_m[n]}) begin errors++; $display("FAIL readback_Q[%0d] got %h required %h", n, d, q_m[n]); end
      end
      start_run();
      wait_done(lat);
      checks++;
      if (lat !== 1153) begin errors++; $display("FAIL random_latency got %0d required 1153", lat); end
      read_outputs();
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (got[k] !== model_out(k)) begin errors++; $display("FAIL random_O[%0d] got %h required %h", k, got[k], model_out(k)); end
      end
    end
  endtask

  task automatic test_busy_protect();
    int unsigned lat;
    logic [31:0] d;
    for (int n = 0; n < 64; n++) begin c_m[n] = rand_coef(); q_m[n] = 8'($urandom_range(1, 40)); end
    c_m[0] = 1234; q_m[0] = 8'd7;
    load_block();
    start_run();
    while ((cyc - start_cyc) < 100) begin @(posedge CLK_I); #1; end
    wb_xfer(1'b1, 0, 32'd999, d);
    wb_xfer(1'b1, 64, 32'd5, d);
    wb_xfer(1'b1, 128, 32'd1, d);
    wb_xfer(1'b0, 129, 32'd0, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL busy_status got %h required 1", d); end
    wait_done(lat);
    checks++;
    if (lat !== 1153) begin errors++; $display("FAIL busy_latency got %0d required 1153", lat); end
    wb_xfer(1'b0, 0, 32'd0, d);
    checks++;
    if (d !== 32'd1234) begin errors++; $display("FAIL busy_C0 got %0d required 1234", d); end
    read_outputs();
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (got[k] !== model_out(k)) begin errors++; $display("FAIL busy_O[%0d] got %h required %h", k, got[k], model_out(k)); end
    end
  endtask

  task automatic test_reset_midrun();
    int unsigned lat;
    logic [31:0] d;
    for (int n = 0; n < 64; n++) begin c_m[n] = rand_coef(); q_m[n] = 8'($urandom_range(0, 255)); end
    c_m[5] = 32'h1357_2468;
    load_block();
    start_run();
    while ((cyc - start_cyc) < 499) begin @(posedge CLK_I); #1; end
    ADR_I = 32'd5; WE_I = 1'b0; STB_I = 1'b1; CYC_I = 1'b1;
    @(posedge CLK_I); #1;
    checks++;
    if (ACK_O !== 1'b1 || DAT_O !== 32'h1357_2468) begin
      errors++; $display("FAIL midrun_read got ack=%b dat=%h required 1/13572468", ACK_O, DAT_O);
    end
    #1 RST_I = 1'b0;
    #1;
    checks++;
    if (ACK_O !== 1'b0 || DAT_O !== 32'd0 || INT_O !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_outputs got ack=%b dat=%h int=%b required 0/0/0", ACK_O, DAT_O, INT_O);
    end
    STB_I = 1'b0; CYC_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1 RST_I = 1'b1;
    wb_xfer(1'b0, 129, 32'd0, d);
    checks++;
    if (d !== 32'd0 || INT_O !== 1'b0) begin errors++; $display("FAIL midrun_status got %h int=%b required 0/0", d, INT_O); end
    for (int n = 0; n < 64; n++) begin c_m[n] = rand_coef(); q_m[n] = 8'($urandom_range(0, 255)); end
    load_block();
    start_run();
    wait_done(lat);
    checks++;
    if (lat !== 1153) begin errors++; $display("FAIL midrun_latency got %0d required 1153", lat); end
    read_outputs();
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (got[k] !== model_out(k)) begin errors++; $display("FAIL midrun_O[%0d] got %h required %h", k, got[k], model_out(k)); end
    end
  endtask

  initial begin
    build_zz();
    test_reset();
    test_unity();
    test_rounding();
    test_saturation();
    test_random();
    test_busy_protect();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
